// File: rtl/sphere_frame_sched_if.sv
// Renderer read port and sphere-bank port bundle for sphere_frame_sched.
// Ports (master = scheduler side):
//   Rd_req/Rd_index     renderer read request and sphere index
//   Rd_grant            renderer owns the bank port this cycle (combinational)
//   Rd_valid/Rd_tag     Bank_rpos holds renderer data for sphere Rd_tag
//   Bank_addr/Bank_we   bank address and write enable
//   Bank_wpos/Bank_wvel write data {z,y,x}, 64-bit signed 32.32 per axis
//   Bank_rpos/Bank_rvel read data, valid the cycle after the address
interface sphere_frame_sched_if #(
  parameter int unsigned IW = 2
);
  logic          Rd_req;
  logic [IW-1:0] Rd_index;
  logic          Rd_grant;
  logic          Rd_valid;
  logic [IW-1:0] Rd_tag;
  logic [IW-1:0] Bank_addr;
  logic          Bank_we;
  logic [191:0]  Bank_wpos;
  logic [191:0]  Bank_wvel;
  logic [191:0]  Bank_rpos;
  logic [191:0]  Bank_rvel;

  modport master (
    input  Rd_req, Rd_index, Bank_rpos, Bank_rvel,
    output Rd_grant, Rd_valid, Rd_tag, Bank_addr, Bank_we, Bank_wpos, Bank_wvel
  );

  modport slave (
    output Rd_req, Rd_index, Bank_rpos, Bank_rvel,
    input  Rd_grant, Rd_valid, Rd_tag, Bank_addr, Bank_we, Bank_wpos, Bank_wvel
  );
endinterface

// File: rtl/sphere_frame_sched.sv
// Per-frame physics sequencer for the sphere state bank. Each Frame_Clk rising
// edge walks spheres 0..N_SPHERES-1 through READ -> WAIT -> WRITE, applying
// gravity and a damped floor bounce, while sharing the single bank port with
// renderer reads.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   Frame_Clk        frame tick, rising edge starts a pass
//   bus              renderer + bank port bundle (master side)
//   Upd_busy         pass in progress
//   Frame_done       one-cycle pulse after the last write of a pass
//   Frame_count      completed passes, wraps
//   Overrun_count    dropped frame edges, saturates at 255
module sphere_frame_sched #(
  parameter int unsigned N_SPHERES = 4,
  parameter logic [63:0] GRAVITY_Y = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [63:0] FLOOR_Y   = 64'd0,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Frame_Clk,
  sphere_frame_sched_if.master bus,
  output logic                 Upd_busy,
  output logic                 Frame_done,
  output logic [15:0]          Frame_count,
  output logic [7:0]           Overrun_count
);

  localparam int unsigned IW = $clog2(N_SPHERES);
  localparam int unsigned SW = $clog2(MAX_STALL + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPHERES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] stall, stall_n;
  logic          frame_clk_old;
  logic          pending, pending_n;
  logic          frame_done_n;
  logic [15:0]   frame_count_n;
  logic [7:0]    overrun_n;
  logic          rd_valid;
  logic [IW-1:0] rd_tag;
  logic [191:0]  rpos_q, rvel_q;

  logic          fe;
  logic          grant;
  logic          we;
  logic          capture;
  logic [IW-1:0] addr;

  assign fe       = Frame_Clk & ~frame_clk_old;
  assign Upd_busy = (state != S_IDLE);

  // Next-state, port arbitration and frame bookkeeping
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    stall_n       = stall;
    pending_n     = pending;
    overrun_n     = Overrun_count;
    frame_done_n  = 1'b0;
    frame_count_n = Frame_count;
    grant         = 1'b0;
    we            = 1'b0;
    capture       = 1'b0;

    // Edges arriving mid-pass: queue one, count the rest as overruns
    if (fe && (state != S_IDLE)) begin
      if (!pending) begin
        pending_n = 1'b1;
      end else if (Overrun_count != 8'hFF) begin
        overrun_n = Overrun_count + 8'd1;
      end
    end

    unique case (state)
      S_IDLE: begin
        grant = bus.Rd_req;
        if (fe || pending) begin
          state_n   = S_READ;
          idx_n     = '0;
          pending_n = 1'b0;
        end
      end
      S_READ: begin
        // Renderer may hold off the update read for at most MAX_STALL cycles
        if (bus.Rd_req && (stall < SW'(MAX_STALL))) begin
          grant   = 1'b1;
          stall_n = stall + SW'(1);
        end else begin
          stall_n = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Update data is on the read bus now; the port itself is free
        grant   = bus.Rd_req;
        capture = 1'b1;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        we = 1'b1;
        if (idx == LAST_IDX) begin
          state_n       = S_IDLE;
          frame_done_n  = 1'b1;
          frame_count_n = Frame_count + 16'd1;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = S_READ;
        end
      end
      default: state_n = S_IDLE;
    endcase

    addr = grant ? bus.Rd_index : idx;
  end

  // Control state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      stall         <= '0;
      frame_clk_old <= 1'b0;
      pending       <= 1'b0;
      rd_valid      <= 1'b0;
      rd_tag        <= '0;
      Frame_done    <= 1'b0;
      Frame_count   <= '0;
      Overrun_count <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      stall         <= stall_n;
      frame_clk_old <= Frame_Clk;
      pending       <= pending_n;
      rd_valid      <= grant;
      rd_tag        <= bus.Rd_index;
      Frame_done    <= frame_done_n;
      Frame_count   <= frame_count_n;
      Overrun_count <= overrun_n;
    end
  end

  // Hold the update's read data so WRITE sees stable operands
  always_ff @(posedge Clk) begin
    if (capture) begin
      rpos_q <= bus.Bank_rpos;
      rvel_q <= bus.Bank_rvel;
    end
  end

  logic [63:0] pos_x, pos_y, pos_z;
  logic [63:0] vel_x, vel_y, vel_z;
  logic [63:0] va_y, neg_va_y;
  logic [63:0] pn_x, pn_y, pn_z;
  logic [63:0] pos_y_out, vel_y_out;

  // Integrate: gravity on y, then clamp to the floor with half-speed rebound
  always_comb begin
    {pos_z, pos_y, pos_x} = rpos_q;
    {vel_z, vel_y, vel_x} = rvel_q;
    va_y      = vel_y + GRAVITY_Y;
    neg_va_y  = -va_y;
    pn_x      = pos_x + vel_x;
    pn_y      = pos_y + va_y;
    pn_z      = pos_z + vel_z;
    pos_y_out = pn_y;
    vel_y_out = va_y;
    if ($signed(pn_y) < $signed(FLOOR_Y)) begin
      pos_y_out = FLOOR_Y;
      vel_y_out = 64'($signed(neg_va_y) >>> 1);
    end
  end

  // Reset suppresses a write that would otherwise land in the reset cycle
  assign bus.Bank_we   = we & ~Reset;
  assign bus.Bank_addr = addr;
  assign bus.Bank_wpos = {pn_z, pos_y_out, pn_x};
  assign bus.Bank_wvel = {vel_z, vel_y_out, vel_x};
  assign bus.Rd_grant  = grant;
  assign bus.Rd_valid  = rd_valid;
  assign bus.Rd_tag    = rd_tag;

endmodule

// File: doc/sphere_frame_sched.md
Name: sphere_frame_sched

Overview:
Per-frame physics sequencer for the sphere state bank, which is a single-port synchronous RAM holding position and velocity vectors. On each Frame_Clk rising edge it walks spheres 0..N_SPHERES-1 through read -> integrate -> write-back. It shares the bank port with renderer read requests. Integration applies gravity, then floor-bounce with damping; a frame edge that arrives mid-pass is queued.

Parameters:
N_SPHERES, 4, number of spheres in the bank (power of 2, index width IW = log2(N_SPHERES))
GRAVITY_Y, 64'hFFFFFFFFFFFF0000, per-frame y acceleration, signed 32.32 (i.e. -(1<<16))
FLOOR_Y, 64'd0, signed 32.32 floor height
MAX_STALL, 8, consecutive renderer-won cycles before the update read is forced

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Frame_Clk  in  1  frame tick, synchronous to Clk, rising edge starts a pass
Rd_req  in  1  renderer read request
Rd_index  in  IW  renderer sphere index
Rd_grant  out  1  combinational; renderer owns the bank port this cycle
Rd_valid  out  1  Bank_rpos holds renderer data (one cycle after grant)
Rd_tag  out  IW  index for the Rd_valid data
Bank_addr  out  IW  bank address
Bank_we  out  1  bank write enable
Bank_wpos  out  192  write position {z,y,x}, 64-bit 32.32 each, y = [1]
Bank_wvel  out  192  write velocity, same layout
Bank_rpos  in  192  read position, valid the cycle after the address
Bank_rvel  in  192  read velocity
Upd_busy  out  1  pass in progress (state != IDLE)
Frame_done  out  1  one-cycle pulse after the last write of a pass
Frame_count  out  16  completed passes, wraps mod 2^16
Overrun_count  out  8  frame edges dropped, saturates at 255

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, idx=0, Frame_Clk_old=0, pending=0, stall=0, Rd_valid=0, Rd_tag=0, Frame_done=0, Frame_count=0, Overrun_count=0. Bank_we=0 combinationally.
- Reset mid-pass: abandon the pass immediately. No write is issued in the reset cycle.
- Edge detect: fe = Frame_Clk & ~Frame_Clk_old, with Frame_Clk_old registered every cycle.
- Pending flag:
  - IDLE & (fe | pending): go to READ, idx=0, clear pending.
  - fe while busy and pending=0: set pending.
  - fe while busy and pending=1: Overrun_count++ (saturating).
- READ: Bank_addr = idx, Bank_we = 0.
  - Renderer wins if Rd_req & stall < MAX_STALL: Rd_grant=1, Bank_addr=Rd_index, stall++, stay in READ.
  - Otherwise update wins: Rd_grant=0, stall=0, go to WAIT.
- WAIT: the port is free, so the renderer is granted if Rd_req. Then go to WRITE.
- WRITE: capture Bank_rpos/Bank_rvel (data for the READ issued two cycles earlier; the bench must not depend on latch timing, only results). Drive Bank_we=1, Bank_addr=idx, Rd_grant=0.
  - If idx == N_SPHERES-1: go to IDLE, pulse Frame_done next cycle, Frame_count++.
  - Else idx++ and go to READ.
  - Implementation must register rdata at the end of WAIT so WRITE uses stable data. The renderer's WAIT-granted read returns during WRITE.
- IDLE: Rd_grant = Rd_req.
- Rd_valid/Rd_tag: registered copy of Rd_grant/Rd_index.
- Arithmetic: per axis, 64-bit two's complement, wrap mod 2^64.
  - va = vel + acc, with acc = {0, GRAVITY_Y, 0}.
  - pn = pos + va.
  - vn = va.
- Floor bounce: if $signed(pn[1]) < $signed(FLOOR_Y), then pn[1] = FLOOR_Y and vn[1] = arithmetic-shift-right-by-1 of (-va[1]). The x and z axes are unaffected.
- Minimum pass latency: 3*N_SPHERES cycles with no renderer traffic (12 for the default). Upd_busy is high for exactly those cycles.
- Simultaneous Rd_req and WRITE: the write wins and the renderer waits.
- Simultaneous fe and the final WRITE: the edge sets pending. IDLE restarts the next cycle with no loss.

Test Plan:
- Reset, then sphere0 pos.y=304<<32, vel=0, one fe, no Rd_req -> Upd_busy high for 12 cycles; sphere0 write vel.y=64'hFFFFFFFFFFFF0000, pos.y=64'h0000012FFFFF0000; Frame_done pulse; Frame_count=1.
- Floor: pos.y=64'h8000, vel.y=0 -> written pos.y=0, vel.y=64'h8000; x/z unchanged.
- Rd_req held high for the whole pass, MAX_STALL=8 -> each READ grants the renderer 8 cycles, then the update on the 9th. Rd_valid follows every grant by one cycle with the correct Rd_tag. Pass completes in 4*(9+2)=44 cycles.
- Two fe within one pass, then a third -> first extra sets pending, second extra gives Overrun_count=1; a second pass starts the cycle after Frame_done; Frame_count=2.
- Reset asserted during sphere 2 WRITE -> no Bank_we in that cycle; all outputs at reset values next cycle; sphere 2 and 3 bank contents unchanged.
- Wrap: vel.x=64'h7FFFFFFFFFFFFFFF, pos.x=1 -> pos.x=64'h8000000000000000 (mod 2^64, no saturation).
